// File: rtl/mem_access_unit_pkg.sv
// Shared definitions for the MEM-stage load/store unit: bus widths, funct3 width
// codes, FSM state encoding and the request legality check.
package mem_access_unit_pkg;

    localparam int RAMAddrBus = 32;
    localparam int RAMDataBus = 32;

    localparam logic [RAMDataBus-1:0] ZeroWord = '0;

    localparam logic [2:0] LSU_B  = 3'b000;
    localparam logic [2:0] LSU_H  = 3'b001;
    localparam logic [2:0] LSU_W  = 3'b010;
    localparam logic [2:0] LSU_BU = 3'b100;
    localparam logic [2:0] LSU_HU = 3'b101;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LD     = 3'd1,
        ST_ST_WR  = 3'd2,
        ST_RMW_RD = 3'd3,
        ST_RMW_WR = 3'd4,
        ST_RESP   = 3'd5
    } lsu_state_t;

    // High when a request is misaligned for its width or uses an illegal funct3
    // (011, 11x, or an unsigned width on a store).
    function automatic logic req_is_err(input logic       we,
                                        input logic [2:0] funct3,
                                        input logic [1:0] addr_lo);
        logic bad;
        case (funct3)
            LSU_B:   bad = 1'b0;
            LSU_H:   bad = addr_lo[0];
            LSU_W:   bad = (addr_lo != 2'b00);
            LSU_BU:  bad = we;
            LSU_HU:  bad = we | addr_lo[0];
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/mem_access_unit_lane_align.sv
// Combinational lane logic: load byte/halfword extraction with sign or zero
// extension, and sub-word store merge into a previously read word.
module lsu_lane_align
    import mem_access_unit_pkg::*;
(
    input  logic [2:0]            funct3,
    input  logic [1:0]            addr_lo,
    input  logic [RAMDataBus-1:0] rd_word,
    input  logic [15:0]           st_lo,
    output logic [RAMDataBus-1:0] ld_data,
    output logic [RAMDataBus-1:0] merge_word
);

    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [3:0]  byte_en;
    logic [31:0] st_rep;

    always_comb begin
        case (addr_lo)
            2'd0:    ld_byte = rd_word[7:0];
            2'd1:    ld_byte = rd_word[15:8];
            2'd2:    ld_byte = rd_word[23:16];
            default: ld_byte = rd_word[31:24];
        endcase
        ld_half = addr_lo[1] ? rd_word[31:16] : rd_word[15:0];
    end

    always_comb begin
        case (funct3)
            LSU_B:   ld_data = {{24{ld_byte[7]}}, ld_byte};
            LSU_BU:  ld_data = {24'd0, ld_byte};
            LSU_H:   ld_data = {{16{ld_half[15]}}, ld_half};
            LSU_HU:  ld_data = {16'd0, ld_half};
            LSU_W:   ld_data = rd_word;
            default: ld_data = ZeroWord;
        endcase
    end

    // Store data is replicated across all lanes; byte_en picks which lanes take it.
    always_comb begin
        if (funct3[0]) begin
            byte_en = addr_lo[1] ? 4'b1100 : 4'b0011;
            st_rep  = {2{st_lo}};
        end else begin
            byte_en = 4'b0001 << addr_lo;
            st_rep  = {4{st_lo[7:0]}};
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            assign merge_word[gi*8 +: 8] = byte_en[gi] ? st_rep[gi*8 +: 8]
                                                       : rd_word[gi*8 +: 8];
        end
    endgenerate

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage initiator for the word-wide data RAM: one request at a time,
// sub-word loads with extension, sub-word stores via read-modify-write.
module mem_access_unit
    import mem_access_unit_pkg::*;
#(
    parameter int ADDR_W = RAMAddrBus,
    parameter int DATA_W = RAMDataBus
) (
    input  logic              i_Clk,
    input  logic              i_reset,
    input  logic              i_req_valid,
    output logic              o_req_ready,
    input  logic              i_req_we,
    input  logic [2:0]        i_req_funct3,
    input  logic [ADDR_W-1:0] i_req_addr,
    input  logic [DATA_W-1:0] i_req_wdata,
    output logic              o_rsp_valid,
    input  logic              i_rsp_ready,
    output logic [DATA_W-1:0] o_rsp_data,
    output logic              o_rsp_err,
    output logic [ADDR_W-1:0] o_ram_r_addr,
    input  logic [DATA_W-1:0] i_ram_r_data,
    output logic              o_ram_we,
    output logic [ADDR_W-1:0] o_ram_w_addr,
    output logic [DATA_W-1:0] o_ram_w_data
);

    lsu_state_t state_reg;
    lsu_state_t state_next;

    logic [2:0]        funct3_reg;
    logic [ADDR_W-1:0] addr_reg;
    logic [DATA_W-1:0] wdata_reg;
    logic [DATA_W-1:0] merge_reg;
    logic [DATA_W-1:0] rsp_data_reg;
    logic              rsp_err_reg;

    logic              accept;
    logic              req_err;
    logic [ADDR_W-1:0] word_addr;
    logic [DATA_W-1:0] align_rd_word;
    logic [DATA_W-1:0] ld_data;
    logic [DATA_W-1:0] merge_word;

    assign accept    = i_req_valid && (state_reg == ST_IDLE);
    assign req_err   = req_is_err(i_req_we, i_req_funct3, i_req_addr[1:0]);
    assign word_addr = {addr_reg[ADDR_W-1:2], 2'b00};

    // Loads extract from the live RAM word; the merge works on the captured one.
    assign align_rd_word = (state_reg == ST_RMW_WR) ? merge_reg : i_ram_r_data;

    lsu_lane_align u_lane_align (
        .funct3     (funct3_reg),
        .addr_lo    (addr_reg[1:0]),
        .rd_word    (align_rd_word),
        .st_lo      (wdata_reg[15:0]),
        .ld_data    (ld_data),
        .merge_word (merge_word)
    );

    always_ff @(posedge i_Clk or posedge i_reset) begin
        if (i_reset) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: begin
                if (accept) begin
                    if (req_err)                    state_next = ST_RESP;
                    else if (!i_req_we)             state_next = ST_LD;
                    else if (i_req_funct3 == LSU_W) state_next = ST_ST_WR;
                    else                            state_next = ST_RMW_RD;
                end
            end
            ST_LD:     state_next = ST_RESP;
            ST_ST_WR:  state_next = ST_RESP;
            ST_RMW_RD: state_next = ST_RMW_WR;
            ST_RMW_WR: state_next = ST_RESP;
            ST_RESP:   if (i_rsp_ready) state_next = ST_IDLE;
            default:   state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        o_req_ready  = 1'b0;
        o_rsp_valid  = 1'b0;
        o_ram_r_addr = '0;
        o_ram_we     = 1'b0;
        o_ram_w_addr = '0;
        o_ram_w_data = ZeroWord;
        case (state_reg)
            ST_IDLE:   o_req_ready = ~i_reset;
            ST_LD:     o_ram_r_addr = word_addr;
            ST_RMW_RD: o_ram_r_addr = word_addr;
            ST_ST_WR: begin
                o_ram_we     = 1'b1;
                o_ram_w_addr = word_addr;
                o_ram_w_data = wdata_reg;
            end
            ST_RMW_WR: begin
                o_ram_we     = 1'b1;
                o_ram_w_addr = word_addr;
                o_ram_w_data = merge_word;
            end
            ST_RESP:   o_rsp_valid = 1'b1;
            default:   o_req_ready = 1'b0;
        endcase
    end

    // Response data is cleared on accept so stores and errors return zero.
    always_ff @(posedge i_Clk or posedge i_reset) begin
        if (i_reset) begin
            funct3_reg   <= 3'd0;
            addr_reg     <= '0;
            wdata_reg    <= ZeroWord;
            merge_reg    <= ZeroWord;
            rsp_data_reg <= ZeroWord;
            rsp_err_reg  <= 1'b0;
        end else begin
            if (accept) begin
                funct3_reg   <= i_req_funct3;
                addr_reg     <= i_req_addr;
                wdata_reg    <= i_req_wdata;
                rsp_data_reg <= ZeroWord;
                rsp_err_reg  <= req_err;
            end
            if (state_reg == ST_LD) begin
                rsp_data_reg <= ld_data;
            end
            if (state_reg == ST_RMW_RD) begin
                merge_reg <= i_ram_r_data;
            end
        end
    end

    assign o_rsp_data = rsp_data_reg;
    assign o_rsp_err  = rsp_err_reg;

endmodule

// File: tb/tb_mem_access_unit.sv
// Randomized plus directed bench for mem_access_unit against a word-array
// reference model of RV32I load/store semantics.
module tb_mem_access_unit;

    logic        i_Clk = 1'b0;
    logic        i_reset = 1'b1;
    logic        i_req_valid = 1'b0;
    logic        o_req_ready;
    logic        i_req_we = 1'b0;
    logic [2:0]  i_req_funct3 = 3'd0;
    logic [31:0] i_req_addr = '0;
    logic [31:0] i_req_wdata = '0;
    logic        o_rsp_valid;
    logic        i_rsp_ready = 1'b0;
    logic [31:0] o_rsp_data;
    logic        o_rsp_err;
    logic [31:0] o_ram_r_addr;
    logic [31:0] i_ram_r_data;
    logic        o_ram_we;
    logic [31:0] o_ram_w_addr;
    logic [31:0] o_ram_w_data;

    logic [31:0] ram     [0:255];
    logic [31:0] ref_mem [0:255];
    int          we_count = 0;
    logic [31:0] last_w_addr = '0;
    int          n_checks = 0;
    int          n_errors = 0;
    int          txn_count = 0;

    always #5 i_Clk = ~i_Clk;

    mem_access_unit dut (
        .i_Clk        (i_Clk),
        .i_reset      (i_reset),
        .i_req_valid  (i_req_valid),
        .o_req_ready  (o_req_ready),
        .i_req_we     (i_req_we),
        .i_req_funct3 (i_req_funct3),
        .i_req_addr   (i_req_addr),
        .i_req_wdata  (i_req_wdata),
        .o_rsp_valid  (o_rsp_valid),
        .i_rsp_ready  (i_rsp_ready),
        .o_rsp_data   (o_rsp_data),
        .o_rsp_err    (o_rsp_err),
        .o_ram_r_addr (o_ram_r_addr),
        .i_ram_r_data (i_ram_r_data),
        .o_ram_we     (o_ram_we),
        .o_ram_w_addr (o_ram_w_addr),
        .o_ram_w_data (o_ram_w_data)
    );

    // RAM: 1 KiB window, combinational read, synchronous write
    assign i_ram_r_data = ram[o_ram_r_addr[9:2]];

    always @(posedge i_Clk) begin
        if (o_ram_we) begin
            ram[o_ram_w_addr[9:2]] <= o_ram_w_data;
            we_count    <= we_count + 1;
            last_w_addr <= o_ram_w_addr;
        end
    end

    task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference behaviour from the ISA rules, applied to ref_mem
    function automatic void model_access(input logic we, input logic [2:0] f3,
                                         input logic [31:0] addr, input logic [31:0] wdata,
                                         output logic [31:0] d, output logic e,
                                         output int lat, output int wes);
        logic        mis, ill;
        logic [31:0] word, b, h, mask;
        int          sh;
        mis = ((f3 == 3'd1 || f3 == 3'd5) && addr[0]) || (f3 == 3'd2 && addr[1:0] != 2'd0);
        ill = (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7) || (we && f3 >= 3'd4);
        e = mis || ill;
        d = 32'd0;
        wes = 0;
        lat = 1;
        if (e) return;
        word = ref_mem[addr[9:2]];
        sh   = int'(addr[1:0]) * 8;
        b    = (word >> sh) & 32'hFF;
        h    = (word >> sh) & 32'hFFFF;
        if (!we) begin
            lat = 2;
            case (f3)
                3'd0:    d = (b >= 32'h80) ? (b | 32'hFFFFFF00) : b;
                3'd4:    d = b;
                3'd1:    d = (h >= 32'h8000) ? (h | 32'hFFFF0000) : h;
                3'd5:    d = h;
                default: d = word;
            endcase
        end else begin
            wes = 1;
            if (f3 == 3'd2) begin
                lat = 2;
                ref_mem[addr[9:2]] = wdata;
            end else begin
                lat  = 3;
                mask = (f3 == 3'd0) ? 32'hFF : 32'hFFFF;
                ref_mem[addr[9:2]] = (word & ~(mask << sh)) | ((wdata & mask) << sh);
            end
        end
    endfunction

    // Called at a negedge with the unit idle; returns at a negedge after the handshake.
    task automatic run_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] wdata, input int hold,
                           output logic [31:0] d, output logic e, output int lat, output int wes);
        int base;
        check_value("req_ready_idle", 32'(o_req_ready), 32'd1);
        base         = we_count;
        i_req_valid  = 1'b1;
        i_req_we     = we;
        i_req_funct3 = f3;
        i_req_addr   = addr;
        i_req_wdata  = wdata;
        @(posedge i_Clk);
        @(negedge i_Clk);
        i_req_valid = 1'b0;
        check_value("accepted", 32'(o_req_ready), 32'd0);
        lat = 1;
        while (!o_rsp_valid && lat < 8) begin
            @(posedge i_Clk);
            @(negedge i_Clk);
            lat++;
        end
        check_value("rsp_seen", 32'(o_rsp_valid), 32'd1);
        d = o_rsp_data;
        e = o_rsp_err;
        for (int k = 0; k < hold; k++) begin
            @(posedge i_Clk);
            @(negedge i_Clk);
            check_value("hold_valid", 32'(o_rsp_valid), 32'd1);
            check_value("hold_data", o_rsp_data, d);
            check_value("hold_err", 32'(o_rsp_err), 32'(e));
            check_value("hold_req_ready", 32'(o_req_ready), 32'd0);
            check_value("hold_r_addr", o_ram_r_addr, 32'd0);
        end
        i_rsp_ready = 1'b1;
        @(posedge i_Clk);
        @(negedge i_Clk);
        i_rsp_ready = 1'b0;
        check_value("rsp_dropped", 32'(o_rsp_valid), 32'd0);
        wes = we_count - base;
    endtask

    task automatic do_txn(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wdata, input int hold);
        logic [31:0] exp_d, got_d;
        logic        exp_e, got_e;
        int          exp_lat, got_lat, exp_wes, got_wes;
        model_access(we, f3, addr, wdata, exp_d, exp_e, exp_lat, exp_wes);
        run_req(we, f3, addr, wdata, hold, got_d, got_e, got_lat, got_wes);
        check_value("rsp_data", got_d, exp_d);
        check_value("rsp_err", 32'(got_e), 32'(exp_e));
        check_value("latency", 32'(got_lat), 32'(exp_lat));
        check_value("we_pulses", 32'(got_wes), 32'(exp_wes));
        if (exp_wes == 1) check_value("w_addr", last_w_addr, {addr[31:2], 2'b00});
        txn_count++;
        $display("txn %0d we=%0d f3=%0d addr=%h wdata=%h -> data=%h err=%0d lat=%0d writes=%0d",
                 txn_count, we, f3, addr, wdata, got_d, got_e, got_lat, got_wes);
    endtask

    task automatic preload(input logic [31:0] addr, input logic [31:0] word);
        ram[addr[9:2]]     = word;
        ref_mem[addr[9:2]] = word;
    endtask

    initial begin
        logic [31:0] r_addr, r_wdata, saved;
        logic [2:0]  r_f3;
        logic        r_we;
        int          base;

        for (int i = 0; i < 256; i++) begin
            ram[i]     = $urandom;
            ref_mem[i] = ram[i];
        end

        // reset state
        #3;
        check_value("rst_req_ready", 32'(o_req_ready), 32'd0);
        check_value("rst_rsp_valid", 32'(o_rsp_valid), 32'd0);
        check_value("rst_ram_we", 32'(o_ram_we), 32'd0);
        check_value("rst_rsp_data", o_rsp_data, 32'd0);
        @(posedge i_Clk);
        @(negedge i_Clk);
        i_reset = 1'b0;
        #1;
        check_value("post_rst_ready", 32'(o_req_ready), 32'd1);
        @(negedge i_Clk);

        // loads from a known word
        preload(32'h100, 32'h8899AABB);
        do_txn(1'b0, 3'd0, 32'h101, 32'h0, 0);
        do_txn(1'b0, 3'd4, 32'h103, 32'h0, 0);
        do_txn(1'b0, 3'd5, 32'h102, 32'h0, 0);
        do_txn(1'b0, 3'd1, 32'h100, 32'h0, 0);

        // word store then load back
        do_txn(1'b1, 3'd2, 32'h200, 32'hDEADBEEF, 0);
        check_value("sw_w_addr", last_w_addr, 32'h200);
        do_txn(1'b0, 3'd2, 32'h200, 32'h0, 0);

        // sub-word stores through read-modify-write
        preload(32'h300, 32'h11223344);
        do_txn(1'b1, 3'd0, 32'h302, 32'h000000A5, 0);
        check_value("sb_word", ram[8'hC0], 32'h11A53344);
        do_txn(1'b1, 3'd1, 32'h300, 32'h00005A5A, 0);
        check_value("sh_word", ram[8'hC0], 32'h11A55A5A);

        // errors: misaligned and illegal funct3
        saved = ram[8'h80];
        do_txn(1'b0, 3'd2, 32'h202, 32'h0, 0);
        do_txn(1'b1, 3'd1, 32'h201, 32'h12345678, 0);
        do_txn(1'b0, 3'd3, 32'h200, 32'h0, 0);
        do_txn(1'b1, 3'd4, 32'h204, 32'hFF, 0);
        check_value("err_ram_intact", ram[8'h80], saved);

        // response back-pressure
        do_txn(1'b0, 3'd1, 32'h302, 32'h0, 5);

        // randomized traffic
        for (int t = 0; t < 150; t++) begin
            r_we    = 1'($urandom_range(0, 1));
            r_f3    = 3'($urandom_range(0, 7));
            r_addr  = $urandom;
            if ($urandom_range(0, 1) == 0) r_addr[1:0] = 2'b00;
            r_wdata = $urandom;
            do_txn(r_we, r_f3, r_addr, r_wdata, $urandom_range(0, 3));
        end

        for (int i = 0; i < 256; i++) begin
            check_value("mem_image", ram[i], ref_mem[i]);
        end

        // asynchronous reset during the RMW write cycle
        preload(32'h300, 32'h11A55A5A);
        base         = we_count;
        i_req_valid  = 1'b1;
        i_req_we     = 1'b1;
        i_req_funct3 = 3'd0;
        i_req_addr   = 32'h300;
        i_req_wdata  = 32'h77;
        @(posedge i_Clk);
        @(negedge i_Clk);
        i_req_valid = 1'b0;
        @(posedge i_Clk);
        #2;
        check_value("pre_rst_we", 32'(o_ram_we), 32'd1);
        #1 i_reset = 1'b1;
        #1;
        check_value("arst_we", 32'(o_ram_we), 32'd0);
        check_value("arst_w_addr", o_ram_w_addr, 32'd0);
        check_value("arst_w_data", o_ram_w_data, 32'd0);
        check_value("arst_r_addr", o_ram_r_addr, 32'd0);
        check_value("arst_rsp_valid", 32'(o_rsp_valid), 32'd0);
        check_value("arst_rsp_data", o_rsp_data, 32'd0);
        check_value("arst_rsp_err", 32'(o_rsp_err), 32'd0);
        check_value("arst_req_ready", 32'(o_req_ready), 32'd0);
        @(posedge i_Clk);
        @(negedge i_Clk);
        i_reset = 1'b0;
        #1;
        check_value("arst_ready_after", 32'(o_req_ready), 32'd1);
        check_value("arst_word_intact", ram[8'hC0], 32'h11A55A5A);
        check_value("arst_no_write", 32'(we_count - base), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
Initiator side of the word-wide data RAM port, located in the MEM stage of the core. Accepts one load/store request at a time over a valid/ready handshake. Drives the RAM's combinational read port and synchronous write port. Performs byte/halfword extraction and sign extension for loads, and read-modify-write merging for sub-word stores, because the RAM has a single whole-word write enable. Returns each result over a valid/ready response channel.

Parameters:
ADDR_W, 32, byte-address width; matches RAMAddrBus.
DATA_W, 32, data width; matches RAMDataBus. Fixed at 32; no other value is supported.

Ports:
i_Clk  in  1  clock; all state updates on rising edge
i_reset  in  1  asynchronous, active-high reset
i_req_valid  in  1  request present
o_req_ready  out  1  unit can accept a request; high only in IDLE
i_req_we  in  1  1 = store, 0 = load
i_req_funct3  in  3  RV32I width code: 000 B, 001 H, 010 W, 100 BU, 101 HU (BU/HU valid for loads only)
i_req_addr  in  32  byte address
i_req_wdata  in  32  store data, right-aligned
o_rsp_valid  out  1  response present
i_rsp_ready  in  1  consumer accepts response
o_rsp_data  out  32  load result, extended; 0 for stores and errors
o_rsp_err  out  1  misaligned access or illegal funct3
o_ram_r_addr  out  32  RAM read address, bits [1:0] = 0
i_ram_r_data  in  32  RAM read data, combinational from o_ram_r_addr
o_ram_we  out  1  RAM write enable
o_ram_w_addr  out  32  RAM write address, bits [1:0] = 0
o_ram_w_data  out  32  RAM write word

Behaviour:
- Reset (asynchronous, active-high):
  - State goes to IDLE.
  - All outputs are 0, except o_req_ready, which is 1 once reset is deasserted.
  - Reset in any state aborts the operation. If reset is asserted during ST_WR or RMW_WR, o_ram_we drops immediately, so no partial write commits.
- Request handshake: a request is accepted when i_req_valid & o_req_ready at a rising edge (cycle N). At that edge, we, funct3, addr, and wdata are registered.
- Request check at accept:
  - Misaligned if H/HU with addr[0] = 1, or W with addr[1:0] != 0.
  - Illegal if funct3 is 011, 11x, or store with funct3 >= 100.
  - Either case goes to RESP with o_rsp_err = 1 and o_rsp_data = 0. No RAM access occurs.
- States: IDLE, LD, ST_WR, RMW_RD, RMW_WR, RESP.
  - IDLE -> LD (load), ST_WR (SW), RMW_RD (SB/SH), RESP (error).
  - LD:
    - Drive o_ram_r_addr = {addr[31:2], 2'b00}.
    - Select the byte lane addr[1:0] or halfword lane addr[1].
    - Sign-extend for B/H, zero-extend for BU/HU.
    - Register the result into o_rsp_data, then go to RESP.
  - ST_WR: o_ram_we = 1, w_addr = aligned addr, w_data = wdata, then go to RESP.
  - RMW_RD: drive the read address and capture i_ram_r_data into a merge register, then go to RMW_WR.
  - RMW_WR:
    - o_ram_we = 1.
    - w_data = captured word with lane(s) replaced by wdata[7:0] (SB) or wdata[15:0] (SH), at the position given by addr[1:0].
    - Then go to RESP.
  - RESP: o_rsp_valid = 1. o_rsp_data and o_rsp_err are held stable until i_rsp_ready is sampled high, then go to IDLE.
- o_ram_we is high only in ST_WR and RMW_WR, for exactly one cycle per store.
- o_ram_r_addr is 0 outside LD and RMW_RD.
- Latency from accept edge N to o_rsp_valid:
  - Error: N+1.
  - Load or SW: N+2.
  - SB/SH: N+3.
- Throughput: no overlap between requests. The earliest next accept is the cycle after the response handshake.
- Back-to-back: a store followed by a load to the same word returns the stored value, because the write commits before RESP.
- No internal wrap: addr[31:2] passes through unmodified to the RAM.

Decomposition:
- Shared defines: funct3 width codes (LSU_B, LSU_H, LSU_W, LSU_BU, LSU_HU), state encodings, and a ZeroWord reuse. Data and address widths reuse RAMDataBus and RAMAddrBus.
- One natural sub-module: lsu_lane_align. It is purely combinational and performs load extraction/extension plus store-lane merge.
- The FSM and registers stay in mem_access_unit.

Test Plan:
- RAM word 0x100 = 0x8899AABB; LB @0x101 -> rsp_data 0xFFFFFFAA at N+2; LBU @0x103 -> 0x00000088; LHU @0x102 -> 0x00008899; LH @0x100 -> 0xFFFFAABB.
- SW 0xDEADBEEF @0x200 -> exactly one o_ram_we pulse with w_addr 0x200; rsp_valid at N+2; then LW @0x200 -> 0xDEADBEEF.
- Word 0x300 = 0x11223344; SB 0xA5 @0x302 -> RMW writes 0x11A53344; SH 0x5A5A @0x300 -> 0x11A55A5A; rsp_valid at N+3.
- LW @0x202, SH @0x201, funct3 = 011 -> rsp_err = 1 and rsp_data = 0 at N+1; o_ram_we never asserted; RAM contents unchanged.
- Hold i_rsp_ready = 0 for 5 cycles -> rsp_valid, rsp_data, and err stay stable; o_req_ready = 0 throughout; the next request is accepted the cycle after the handshake.
- Assert i_reset asynchronously mid-cycle during RMW_WR of SB @0x300 -> o_ram_we falls immediately; word 0x300 unchanged; all outputs 0; o_req_ready = 1 after reset is released.
